// File: rtl/bram_fifo_ctrl.sv
// FWFT FIFO controller driving an external dual-port BRAM (1-cycle read latency)
// with a 2-entry output buffer. Optional same-cycle bypass: BRAM_FIFO_BYPASS_EN.
module bram_fifo_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 128,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [AW+1:0]         level,
  output logic                  ram_ena,
  output logic                  ram_wea,
  output logic [AW-1:0]         ram_addra,
  output logic [DATA_WIDTH-1:0] ram_dina,
  output logic                  ram_enb,
  output logic [AW-1:0]         ram_addrb,
  input  logic [DATA_WIDTH-1:0] ram_doutb
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [AW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]           ram_cnt_q, ram_cnt_d;
  logic                  inflight_q, inflight_d;
  logic [1:0]            buf_cnt_q, buf_cnt_d;
  logic                  head_q, head_d;
  logic [DATA_WIDTH-1:0] obuf_q [2];
  logic [DATA_WIDTH-1:0] obuf_d [2];

  logic                  push_s, pop_s, issue_s, byp_s, ram_wr_s, cap_s, tail_s;
  logic                  in_ready_s, out_valid_s;
  logic [2:0]            credit_s;
  logic [DATA_WIDTH-1:0] cap_data_s;

  // Handshakes, read-issue credit, bypass decision and next state.
  always_comb begin
    in_ready_s  = !rst && (ram_cnt_q < DEPTH_C);
    out_valid_s = !rst && (buf_cnt_q != 2'd0);
    push_s      = in_valid && in_ready_s;
    pop_s       = out_valid_s && out_ready;
    // Slots that will be occupied in obuf once the pending read lands.
    credit_s    = {1'b0, buf_cnt_q} + {2'b00, inflight_q} - {2'b00, pop_s};
    issue_s     = !rst && (ram_cnt_q != {(AW+1){1'b0}}) && (credit_s < 3'd2);
`ifdef BRAM_FIFO_BYPASS_EN
    byp_s       = push_s && (ram_cnt_q == {(AW+1){1'b0}}) && !inflight_q &&
                  (({1'b0, buf_cnt_q} - {2'b00, pop_s}) < 3'd2);
`else
    byp_s       = 1'b0;
`endif
    ram_wr_s    = push_s && !byp_s;
    cap_s       = inflight_q || byp_s;
    cap_data_s  = inflight_q ? ram_doutb : in_data;
    tail_s      = head_q ^ buf_cnt_q[0];

    wptr_d      = wptr_q + {{(AW-1){1'b0}}, ram_wr_s};
    rptr_d      = rptr_q + {{(AW-1){1'b0}}, issue_s};
    ram_cnt_d   = ram_cnt_q + {{AW{1'b0}}, ram_wr_s} - {{AW{1'b0}}, issue_s};
    inflight_d  = issue_s;
    buf_cnt_d   = buf_cnt_q + {1'b0, cap_s} - {1'b0, pop_s};
    head_d      = head_q ^ pop_s;
    obuf_d[0]   = (cap_s && !tail_s) ? cap_data_s : obuf_q[0];
    obuf_d[1]   = (cap_s &&  tail_s) ? cap_data_s : obuf_q[1];
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q     <= {AW{1'b0}};
      rptr_q     <= {AW{1'b0}};
      ram_cnt_q  <= {(AW+1){1'b0}};
      inflight_q <= 1'b0;
      buf_cnt_q  <= 2'd0;
      head_q     <= 1'b0;
      obuf_q[0]  <= {DATA_WIDTH{1'b0}};
      obuf_q[1]  <= {DATA_WIDTH{1'b0}};
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      ram_cnt_q  <= ram_cnt_d;
      inflight_q <= inflight_d;
      buf_cnt_q  <= buf_cnt_d;
      head_q     <= head_d;
      obuf_q[0]  <= obuf_d[0];
      obuf_q[1]  <= obuf_d[1];
    end
  end

  // Output mapping; status outputs are forced to zero while in reset.
  always_comb begin
    in_ready  = in_ready_s;
    out_valid = out_valid_s;
    ram_ena   = ram_wr_s;
    ram_wea   = ram_wr_s;
    ram_addra = wptr_q;
    ram_dina  = in_data;
    ram_enb   = issue_s;
    ram_addrb = rptr_q;
    if (rst) begin
      out_data = {DATA_WIDTH{1'b0}};
      level    = {(AW+2){1'b0}};
    end else begin
      out_data = obuf_q[head_q];
      level    = {1'b0, ram_cnt_q} + {{(AW+1){1'b0}}, inflight_q} +
                 {{AW{1'b0}}, buf_cnt_q};
    end
  end

endmodule
